// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and word helpers for the key schedule and
// the encryption core.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef logic [31:0]   word_t;
  typedef logic [KW-1:0] rkey_t;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. The table is packed with entry 0
// in the most significant byte so each row below reads as in FIPS-197.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] sel_s;

  // bit offset of entry x, counted from the LSB end of the packed table
  always_comb begin
    sel_s = {8'hff - x, 3'b000};
    y     = SBOX[sel_s +: 8];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry
// register file with a registered read port. AES_KEY_STREAM_EN adds a stream out.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic          busy,
  output logic          done,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_out
`ifdef AES_KEY_STREAM_EN
  ,
  output logic          rk_stream_valid,
  output logic [KW-1:0] rk_stream_data
`endif
);

  logic       busy_r;
  logic       done_r;
  logic [3:0] cnt_r;
  rkey_t      rk_r [0:NR];
  rkey_t      rk_out_r;

  logic       accept_s;
  logic       last_s;
  rkey_t      prev_s;
  rkey_t      rd_s;
  rkey_t      next_s;
  logic [7:0] rcon_s;
  word_t      rot_s;
  word_t      sub_s;
  word_t      t_s;
  word_t      n0_s, n1_s, n2_s, n3_s;

  assign accept_s  = key_valid & ~busy_r;
  assign last_s    = busy_r & (cnt_r == 4'd10);
  assign key_ready = ~busy_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rk_out    = rk_out_r;

  // select previous round key, Rcon and the read-port entry
  always_comb begin
    prev_s = '0;
    rcon_s = 8'h00;
    rd_s   = '0;
    for (int i = 0; i < NR; i++) begin
      prev_s = (cnt_r == 4'(i + 1)) ? rk_r[i] : prev_s;
    end
    for (int i = 1; i <= NR; i++) begin
      rcon_s = (cnt_r == 4'(i)) ? RCON[i] : rcon_s;
    end
    for (int i = 0; i <= NR; i++) begin
      rd_s = (rk_idx == 4'(i)) ? rk_r[i] : rd_s;
    end
  end

  assign rot_s = rot_word(prev_s[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x (rot_s[8*g +: 8]),
      .y (sub_s[8*g +: 8])
    );
  end

  // one round of the AES-128 schedule
  always_comb begin
    t_s    = sub_s ^ {rcon_s, 24'h000000};
    n0_s   = prev_s[127:96] ^ t_s;
    n1_s   = prev_s[95:64]  ^ n0_s;
    n2_s   = prev_s[63:32]  ^ n1_s;
    n3_s   = prev_s[31:0]   ^ n2_s;
    next_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // control, register file and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= 4'd0;
      rk_out_r <= '0;
      for (int i = 0; i <= NR; i++) begin
        rk_r[i] <= '0;
      end
    end else begin
      rk_out_r <= rd_s;
      if (accept_s) begin
        rk_r[0] <= key_in;
        cnt_r   <= 4'd1;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end else if (busy_r) begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_r == 4'(i)) begin
            rk_r[i] <= next_s;
          end
        end
        if (last_s) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          cnt_r  <= 4'd0;
        end else begin
          cnt_r <= cnt_r + 4'd1;
        end
      end
    end
  end

`ifdef AES_KEY_STREAM_EN
  logic  sv_r;
  logic  lr_r;
  rkey_t sd_r;

  // stream: entry cnt-1 while busy, then round 10 one edge after it lands
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_r <= 1'b0;
      lr_r <= 1'b0;
      sd_r <= '0;
    end else begin
      lr_r <= last_s;
      sv_r <= busy_r | lr_r;
      sd_r <= lr_r ? rk_r[NR] : prev_s;
    end
  end

  assign rk_stream_valid = sv_r;
  assign rk_stream_data  = sd_r;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander using FIPS-197 key
// schedules; also checks the round-key stream when AES_KEY_STREAM_EN is defined.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KEY_STREAM_EN
  logic         rk_stream_valid;
  logic [127:0] rk_stream_data;
`endif

  int n_vec = 0;
  int n_err = 0;
  int s_cnt = 0;
  logic mon_en = 1'b0;
  logic saw_done;

  logic [127:0] key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] key_b = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] key_x = 128'hdeadbeefcafef00d0123456789abcdef;
  logic [127:0] rka [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] rkb1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  logic [127:0] rkb10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expander dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out)
`ifdef AES_KEY_STREAM_EN
    ,
    .rk_stream_valid (rk_stream_valid),
    .rk_stream_data  (rk_stream_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_rk(input int idx, input logic [127:0] exp_v, input string tag);
    rk_idx = 4'(idx);
    tick();
    chk(tag, rk_out, exp_v);
  endtask

`ifdef AES_KEY_STREAM_EN
  always @(negedge clk) begin
    if (mon_en && rk_stream_valid) begin
      if (s_cnt < 11) begin
        chk("stream_data", rk_stream_data, rka[s_cnt]);
      end else begin
        chk("stream_extra", 128'(s_cnt), 128'd10);
      end
      s_cnt++;
    end
  end
`endif

  initial begin
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_idx    = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // idle after reset
    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_done",  128'(done),      128'd0);
    chk("rst_ready", 128'(key_ready), 128'd1);
    for (int i = 0; i <= 10; i++) read_rk(i, 128'd0, "rst_rk");

    // key A accepted while a different key is held valid through busy
    mon_en    = 1'b1;
    key_in    = key_a;
    key_valid = 1'b1;
    tick();
    key_in = key_x;
    chk("acc_busy", 128'(busy), 128'd1);
    chk("acc_done", 128'(done), 128'd0);
    for (int c = 1; c <= 10; c++) begin
      chk("busy_ready", 128'(key_ready), 128'd0);
      tick();
      if (c < 10) chk("early_done", 128'(done), 128'd0);
    end
    key_valid = 1'b0;
    chk("a_done", 128'(done), 128'd1);
    chk("a_busy", 128'(busy), 128'd0);
    chk("a_ready", 128'(key_ready), 128'd1);
    for (int i = 0; i <= 10; i++) read_rk(i, rka[i], "a_rk");
    for (int i = 11; i <= 15; i++) read_rk(i, 128'd0, "oor_rk");
    mon_en = 1'b0;
`ifdef AES_KEY_STREAM_EN
    chk("stream_count", 128'(s_cnt), 128'd11);
`endif

    // re-key after done
    key_in    = key_b;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("rekey_done", 128'(done), 128'd0);
    chk("rekey_busy", 128'(busy), 128'd1);
    for (int c = 1; c <= 10; c++) tick();
    chk("b_done", 128'(done), 128'd1);
    read_rk(1, rkb1, "b_rk1");
    read_rk(10, rkb10, "b_rk10");
    read_rk(0, key_b, "b_rk0");

    // reset mid-expansion
    key_in    = key_a;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    rk_idx    = 4'd0;
    for (int c = 1; c <= 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  128'(busy),      128'd0);
    chk("abort_done",  128'(done),      128'd0);
    chk("abort_ready", 128'(key_ready), 128'd1);
    chk("abort_rkout", rk_out,          128'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      saw_done = saw_done | done;
    end
    chk("abort_nodone", 128'(saw_done), 128'd0);
    read_rk(10, 128'd0, "abort_rk10");

    // fresh key after the abort
    key_in    = key_b;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    chk("post_done", 128'(done), 128'd1);
    read_rk(10, rkb10, "post_rk10");
    read_rk(1, rkb1, "post_rk1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential AES-128 key schedule. Sits directly upstream of the aesencryption datapath and supplies its round keys.
- Accepts a 128-bit cipher key through a valid/ready handshake. Generates round keys 1..10 at one per clock and stores all 11 (including round 0) in an internal register file.
- The downstream encryption stage reads any round key by index once done is high.

Parameters:
- NR, 10, number of AES-128 rounds; fixed, not overridable.
- KW, 128, key/round-key width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key, MSB = byte 0 (FIPS-197 order).
- key_valid  input  1  key_in is valid this cycle.
- key_ready  output  1  block can accept a key; equals !busy.
- busy  output  1  expansion in progress.
- done  output  1  all 11 round keys valid; held until the next key is accepted or reset.
- rk_idx  input  4  round-key index to read, 0..10.
- rk_out  output  128  registered round key for rk_idx, one cycle read latency.

Behaviour:
- Reset (rst=1 at clock edge) clears the following:
  - busy=0, done=0, rk_out=0.
  - Round counter = 0.
  - All 11 register-file entries = 0.
  - Reset mid-expansion aborts immediately; no partial done.
- key_ready = !busy, combinational. A key is accepted on an edge where key_valid && key_ready.
- Accept edge T:
  - rk[0] <= key_in, counter <= 1, busy <= 1, done <= 0.
  - done drops even if it was 1; re-keying after completion is allowed.
- Edges T+1..T+10: rk[counter] <= f(rk[counter-1], Rcon[counter]), then counter increments.
  - On edge T+10: busy <= 0, done <= 1, counter <= 0.
  - Total latency from accept edge to done high is 10 cycles.
- Round function, with words w0..w3 of the previous key (w0 = MSB word):
  - t = SubWord(RotWord(w3)) XOR {Rcon,00,00,00}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- key_valid while busy=1 is ignored; key_in is not sampled.
- Read port:
  - rk_out <= rk[rk_idx] every edge, regardless of busy/done.
  - rk_idx > 10 gives rk_out <= 0.
  - During busy, entries not yet computed read as their prior contents (0 after reset, old key set otherwise); consumers must gate on done.
- Read and write to the same entry on the same edge returns the old value (read-before-write).
- One round per cycle: the critical path is 4 parallel S-box lookups plus an XOR chain.

Optional Feature:
- Macro: AES_KEY_STREAM_EN.
- Defined: adds outputs rk_stream_valid (1) and rk_stream_data (128). Each one-cycle pulse presents a newly written round key, in order:
  - Round 0 on the edge after accept.
  - Round i on the edge after its write.
  - 11 pulses per expansion; cleared by reset.
- Not defined: the ports do not exist and no stream register is inferred. Core behaviour is identical either way.

Decomposition:
- Package aes_pkg contains:
  - NR, KW.
  - Rcon table as a constant array indexed 1..10.
  - Typedef for a 32-bit word and a 128-bit round key.
  - Function for RotWord.
- Sub-module aes_sbox: purely combinational 8-bit in / 8-bit out forward S-box. Instantiated 4 times for SubWord and shared later with the encryption core.

Test Plan:
- Reset, then idle: busy=0, done=0, key_ready=1, rk_out=0 for rk_idx=0..10.
- Key 2B7E151628AED2A6ABF7158809CF4F3C accepted:
  - done rises exactly 10 cycles after the accept edge.
  - rk_idx=0 reads back the key.
  - rk_idx=1 gives A0FAFE1788542CB123A339392A6C7605.
  - rk_idx=10 gives D014F9A8C9EE2589E13F0CC8B6630CA6.
- Hold key_valid=1 with a different key for all 10 busy cycles: key_ready=0 throughout, and the stored schedule still matches the FIPS-197 values above.
- After done, accept key 000102030405060708090A0B0C0D0E0F:
  - done drops on the accept edge.
  - After 10 cycles, rk_idx=10 gives 13111D7FE3944A17F307A78B4D2B30C5.
- Assert rst at cycle 5 of an expansion: all outputs return to reset values next cycle, done never asserts, and a subsequent key expands correctly.
- rk_idx=11..15: rk_out=0. With AES_KEY_STREAM_EN defined, count exactly 11 rk_stream_valid pulses carrying rounds 0..10 in order.
